// File: rtl/scan_counter_pkg.sv
// Shared types and helpers for the display-scan counter: mode encoding and
// the prescaler width function.
package scan_pkg;

    typedef enum logic [1:0] {
        UP   = 2'b00,
        DOWN = 2'b01,
        HOLD = 2'b10,
        RSVD = 2'b11
    } scan_mode_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scan_counter_chk.sv
// Elaboration-time legality checks for the scan counter parameters.
module scan_param_chk #(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4,
    parameter int DIV     = 1
) ();

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("scan_counter: MODULUS must lie in 2..2**WIDTH");
    end

    if (DIV < 1) begin : g_bad_div
        $error("scan_counter: DIV must be at least 1");
    end

endmodule

// File: rtl/scan_counter_tick_prescaler.sv
// Divides enabled clock cycles by DIV and emits a combinational step on the
// last cycle of each period; clr restarts the period without a step.
module tick_prescaler
    import scan_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int              PW       = clog2_min1(DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]   PRE_ONE  = PW'(1);

    logic [PW-1:0] pre_r;

    // Prescale phase register; frozen (not cleared) while en is low.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pre_r <= '0;
        end else if (clr) begin
            pre_r <= '0;
        end else if (en) begin
            if (pre_r == PRE_LAST) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end
        end else begin
            pre_r <= pre_r;
        end
    end

    assign step = en && (pre_r == PRE_LAST);

endmodule

// File: rtl/scan_counter.sv
// Parametrised display-scan counter: prescaled modulo-N up/down/hold count
// with load, one-hot digit select and single-cycle tick/wrap strobes.
module scan_counter
    import scan_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int MODULUS        = 4,
    parameter int DIV            = 100000,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   counter,
    output logic [MODULUS-1:0] sel,
    output logic               tick,
    output logic               wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic                step_s;
    logic [WIDTH-1:0]    counter_r;
    logic [WIDTH-1:0]    cnt_next_s;
    logic [WIDTH-1:0]    load_clamp_s;
    logic                wrap_next_s;
    logic                tick_r;
    logic                wrap_r;
    logic [MODULUS-1:0]  onehot_s;

    scan_param_chk #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .DIV     (DIV)
    ) u_chk ();

    tick_prescaler #(
        .DIV (DIV)
    ) u_pre (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (en),
        .clr   (load),
        .step  (step_s)
    );

    // Next count on a step; wrap uses explicit compares so the count never leaves 0..MODULUS-1.
    always_comb begin
        cnt_next_s  = counter_r;
        wrap_next_s = 1'b0;
        case (mode)
            UP: begin
                if (counter_r == CNT_MAX) begin
                    cnt_next_s  = '0;
                    wrap_next_s = 1'b1;
                end else begin
                    cnt_next_s  = counter_r + CNT_ONE;
                end
            end
            DOWN: begin
                if (counter_r == '0) begin
                    cnt_next_s  = CNT_MAX;
                    wrap_next_s = 1'b1;
                end else begin
                    cnt_next_s  = counter_r - CNT_ONE;
                end
            end
            HOLD: begin
                cnt_next_s = counter_r;
            end
            default: begin
                cnt_next_s = counter_r;
            end
        endcase
        load_clamp_s = (load_val > CNT_MAX) ? CNT_MAX : load_val;
    end

    // Count and strobe registers: reset beats load, load discards a coincident step.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            counter_r <= '0;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else if (load) begin
            counter_r <= load_clamp_s;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else if (step_s) begin
            counter_r <= cnt_next_s;
            tick_r    <= 1'b1;
            wrap_r    <= wrap_next_s;
        end else begin
            counter_r <= counter_r;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end
    end

    // Digit select decode, inverted for active-low anodes.
    always_comb begin
        onehot_s = '0;
        for (int k = 0; k < MODULUS; k++) begin
            onehot_s[k] = (counter_r == WIDTH'(k));
        end
        if (SEL_ACTIVE_LOW != 0) begin
            sel = ~onehot_s;
        end else begin
            sel = onehot_s;
        end
    end

    assign counter = counter_r;
    assign tick    = tick_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_scan_counter.sv
// Directed, table-driven bench for scan_counter (MODULUS=4/DIV=3), plus
// hand sequences on MODULUS=3 and DIV=1 instances sharing the same inputs.
module tb_scan_counter;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       ld;
        logic [1:0] lv;
        logic [1:0] cnt;
        logic [3:0] sel;
        logic       tck;
        logic       wrp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       Reset, en, load;
    logic [1:0] mode, load_val;

    logic [1:0] counter, counter_m3, counter_d1;
    logic [3:0] sel, sel_d1;
    logic [2:0] sel_m3;
    logic       tick, wrap, tick_m3, wrap_m3, tick_d1, wrap_d1;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq[$];

    always #5 CLK = ~CLK;

    scan_counter #(.WIDTH(2), .MODULUS(4), .DIV(3), .SEL_ACTIVE_LOW(1)) dut (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .counter(counter), .sel(sel), .tick(tick), .wrap(wrap));

    scan_counter #(.WIDTH(2), .MODULUS(3), .DIV(3), .SEL_ACTIVE_LOW(1)) dut_m3 (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .counter(counter_m3), .sel(sel_m3), .tick(tick_m3), .wrap(wrap_m3));

    scan_counter #(.WIDTH(2), .MODULUS(4), .DIV(1), .SEL_ACTIVE_LOW(1)) dut_d1 (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .counter(counter_d1), .sel(sel_d1), .tick(tick_d1), .wrap(wrap_d1));

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic l, input logic [1:0] lvv, input logic [1:0] c,
                                input logic [3:0] s, input logic t, input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.ld = l; v.lv = lvv;
        v.cnt = c; v.sel = s; v.tck = t; v.wrp = w;
        return v;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic [1:0] lvv);
        Reset = r; en = e; mode = m; load = l; load_val = lvv;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset, then up count: steps on edges 3,6,9,12
        vq.push_back(mk(1, 0, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(1, 0, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 1, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 2, 4'b1011, 1, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 3, 4'b0111, 1, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 1, 1));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        // reset, then down count wrapping 0->3 on the first step
        vq.push_back(mk(1, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 1, 1));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 2, 4'b1011, 1, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 4'b1101, 1, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 1, 1));
        // load 2 on a step edge: step discarded, next step 3 cycles later
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 1, 2, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 2, 4'b1011, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 4'b1101, 1, 0));
        // load with en low mid-period restarts the prescaler
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 0, 2'b01, 1, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b01, 0, 0, 3, 4'b0111, 1, 1));
        // en low for 5 cycles at pre=1; mode toggled while frozen
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 3, 4'b0111, 0, 0));
        for (int i = 0; i < 5; i++) vq.push_back(mk(0, 0, 2'b01, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 3, 4'b0111, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 1, 1));
        // hold, then reserved mode: tick every 3 cycles, no change, no wrap
        vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b10, 0, 0, 0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 1, 2'b11, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b11, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b11, 0, 0, 0, 4'b1110, 1, 0));
        // reset + load + step together, then phase restarts from 0
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 1, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 0, 0));
        vq.push_back(mk(1, 1, 2'b00, 1, 3, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 0, 4'b1110, 0, 0));
        vq.push_back(mk(0, 1, 2'b00, 0, 0, 1, 4'b1101, 1, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].en, vq[i].mode, vq[i].ld, vq[i].lv);
            chk($sformatf("vec%0d counter", i), 8'(counter), 8'(vq[i].cnt));
            chk($sformatf("vec%0d sel", i),     8'(sel),     8'(vq[i].sel));
            chk($sformatf("vec%0d tick", i),    8'(tick),    8'(vq[i].tck));
            chk($sformatf("vec%0d wrap", i),    8'(wrap),    8'(vq[i].wrp));
        end

        // DIV=1: steps every enabled cycle, tick stays high
        drive(1, 0, 2'b00, 0, 0);
        chk("d1 reset counter", 8'(counter_d1), 8'd0);
        chk("d1 reset tick", 8'(tick_d1), 8'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 2'b00, 0, 0);
            chk($sformatf("d1 step%0d counter", i), 8'(counter_d1), 8'(i % 4));
            chk($sformatf("d1 step%0d tick", i), 8'(tick_d1), 8'd1);
            chk($sformatf("d1 step%0d wrap", i), 8'(wrap_d1), (i == 4) ? 8'd1 : 8'd0);
        end

        // MODULUS=3 clamp and wrap at 2 (not 3)
        drive(1, 0, 2'b00, 0, 0);
        drive(0, 0, 2'b00, 1, 3);
        chk("m3 clamp counter", 8'(counter_m3), 8'd2);
        chk("m3 clamp sel", 8'(sel_m3), 8'h03);
        chk("m4 load3 counter", 8'(counter), 8'd3);
        chk("m4 load3 sel", 8'(sel), 8'h07);
        drive(0, 1, 2'b00, 0, 0);
        drive(0, 1, 2'b00, 0, 0);
        drive(0, 1, 2'b00, 0, 0);
        chk("m3 wrap counter", 8'(counter_m3), 8'd0);
        chk("m3 wrap sel", 8'(sel_m3), 8'h06);
        chk("m3 wrap tick", 8'(tick_m3), 8'd1);
        chk("m3 wrap wrap", 8'(wrap_m3), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_counter.md
# scan_counter

Parametrised display-scan counter replacing the fixed 2-bit free-running counter in the seven-segment display path. It divides `CLK` by a programmable ratio and steps a modulo-N counter up or down, with hold, load and enable. It also produces a one-hot digit select plus single-cycle tick and wrap strobes. It sits between the board clock and the digit/anode multiplexer, and the count also serves as a general-purpose slow timebase.

## Interface
- `WIDTH`, default 2: counter width in bits.
- `MODULUS`, default 4: count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- `DIV`, default 100000: prescale ratio, ≥ 1. The counter steps once per DIV enabled cycles.
- `SEL_ACTIVE_LOW`, default 1: 1 inverts `sel` for active-low anodes.
- `CLK`  in  1  system clock. All logic is on the rising edge.
- `Reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `en`  in  1  prescaler/count enable.
- `mode`  in  2  00 up, 01 down, 10 hold, 11 reserved (behaves as hold).
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `counter`  out  WIDTH  current count, registered.
- `sel`  out  MODULUS  one-hot decode of `counter`, polarity per SEL_ACTIVE_LOW.
- `tick`  out  1  one-cycle pulse, high in the cycle after each step.
- `wrap`  out  1  one-cycle pulse, high in the cycle after a step that wrapped.

## Operation
- Prescaler `pre` is a register of width clog2(DIV), minimum 1 bit.
- Internal `step = en && pre == DIV-1`. With DIV=1, `step = en`.
- With `en`=1, `pre` increments and returns to 0 on the `step` edge.
- With `en`=0, `pre`, `counter` and `tick`/`wrap` inputs are frozen. The prescaler is not cleared.
- Behaviour on a `step` edge, by mode:
  - Up: `counter`+1. At MODULUS-1 it goes to 0 and `wrap` is set.
  - Down: `counter`-1. At 0 it goes to MODULUS-1 and `wrap` is set.
  - Hold or reserved: `counter` is unchanged, `tick` still pulses, `wrap` stays 0.
- Load:
  - `counter` ← `load_val` if `load_val` < MODULUS, else ← MODULUS-1 (clamp).
  - `pre` ← 0, `tick` ← 0, `wrap` ← 0.
  - Load is independent of `en`.
- Priority: `Reset` > `load` > `step`. A `step` coincident with `load` is discarded.
- `mode` is sampled only on `step` edges. Changing it between steps has no side effect.
- `sel` is decoded combinationally from the `counter` register:
  - Bit k is active when `counter` == k.
  - With SEL_ACTIVE_LOW=1, active means 0.
  - Exactly one bit is active at all times.
- Arithmetic: wrap is by explicit compare against MODULUS-1 / 0, never natural WIDTH overflow. `counter` never holds a value ≥ MODULUS.

## Timing
- Reset values: `counter`=0, `pre`=0, `tick`=0, `wrap`=0.
- `sel` after reset is bit 0 active: with MODULUS=4 and SEL_ACTIVE_LOW=1, `sel`=4'b1110.
- Reset asserted mid-count takes effect at the next edge regardless of `load`, `en` or `mode`.
- Counting resumes on the first edge after `Reset` deasserts. The first step occurs DIV enabled cycles later.
- Load latency is 1 edge. `sel` follows `counter` in the same cycle.
- Step latency:
  - `counter` changes on the `step` edge.
  - `tick`/`wrap` are high during the following cycle only, concurrent with the new `counter`.
- Step period is exactly DIV enabled cycles. `en` low cycles stretch the period without losing phase.

## Structure
- Shared package `scan_pkg`:
  - `scan_mode_t` enum: UP=2'b00, DOWN=2'b01, HOLD=2'b10, RSVD=2'b11.
  - Helper function `clog2_min1` for the prescaler width.
- Sub-module `tick_prescaler`:
  - Parameter DIV; inputs `CLK`, `Reset`, `en`, `clr`; output `step`.
  - `clr` is driven by `load`.
- The top level holds the counter, the strobe registers and the `sel` decode.
- Parameter legality (MODULUS, DIV range) is checked with elaboration-time assertions.

## Test plan
All scenarios use WIDTH=2, MODULUS=4, DIV=3, SEL_ACTIVE_LOW=1 unless stated.
- **Up count:** Reset 2 cycles, then `en`=1, `mode`=UP for 14 cycles.
  - `counter` steps 0→1→2→3→0 on cycles 3, 6, 9, 12.
  - `tick` is high on cycles 4, 7, 10, 13.
  - `wrap` is high only on cycle 13.
  - `sel` sequence is 1110, 1101, 1011, 0111, 1110.
- **Down count:** from reset, `mode`=DOWN.
  - First step gives `counter`=3 with `wrap`=1 in the next cycle.
  - Then 2, 1, 0, with no further `wrap` until the step back to 3.
- **Load coincident with step:** assert `load`, `load_val`=2 on the step edge.
  - `counter`=2, `pre`=0, `tick`=0.
  - Next step occurs 3 cycles later.
- **Load clamp:** with MODULUS=3, `load_val`=3 gives `counter`=2. `sel` shows bit 2 active.
- **Enable and hold:** drop `en` for 5 cycles at `pre`=1.
  - `counter` and `pre` are frozen; the step occurs 2 cycles after `en` returns.
  - `mode`=HOLD: `tick` pulses every 3 cycles, `counter` is constant, `wrap`=0.
- **Reset priority and DIV=1:**
  - `Reset`+`load`+`step` in the same cycle gives all outputs at reset values.
  - With DIV=1 and `en`=1, `counter` steps every cycle and `tick` is continuously high after the first step.
